// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and the packed event record for the
// PS/2 key event decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } parse_state_t;

  typedef enum logic {
    P_IDLE = 1'b0,
    P_WAIT = 1'b1
  } pop_state_t;

  // Event record, MSB first: repeat, shift, break, ext, code.
  typedef struct packed {
    logic       rpt;
    logic       shift;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_event_t;

  localparam int KEY_EVENT_W = $bits(key_event_t);

  // Held-bitmap index: extended keys live in the upper half.
  function automatic logic [7:0] held_index(input logic ext, input logic [6:0] code7);
    return {ext, code7};
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_fifo.sv
// First-word-fall-through event FIFO. Simultaneous push and pop are both
// honoured, including when the FIFO is full.
module key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code parser: pops bytes from the receiver, decodes make/break
// and E0-extended sequences, tracks held keys and queues key events.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int COUNT_W    = 8,
  parameter int CNT_SAT    = 0,
  parameter int REPEAT_EN  = 0
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [7:0]         rx_data,
  input  logic               rx_ready,
  input  logic               rx_overflow,
  output logic               rx_next_n,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [7:0]         ev_code,
  output logic               ev_ext,
  output logic               ev_break,
  output logic               ev_shift,
  output logic               ev_repeat,
  output logic               key_down,
  output logic [COUNT_W-1:0] press_count,
  output logic [7:0]         last_make,
  output logic               ps2_ovf
);

  localparam logic [7:0] LSHIFT_IDX = held_index(1'b0, PS2_LSHIFT[6:0]);
  localparam logic [7:0] RSHIFT_IDX = held_index(1'b0, PS2_RSHIFT[6:0]);

  pop_state_t         pop_q, pop_d;
  parse_state_t       parse_q, parse_d;
  logic [7:0]         byte_q, byte_d;
  logic               rx_next_n_q, rx_next_n_d;
  logic [255:0]       held_q, held_d;
  logic               key_down_q, key_down_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]         last_make_q, last_make_d;
  logic               ovf_q, ovf_d;

  logic               is_make;
  logic               is_brk;
  logic               key_ext;
  logic [7:0]         key_idx;
  logic               tracked;
  logic               held_hit;
  logic               shift_now;

  logic               push;
  key_event_t         push_ev;
  key_event_t         head_ev;
  logic [KEY_EVENT_W-1:0] fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  // Pop handshake: grab a byte only when the FIFO can take its event.
  always_comb begin
    pop_d       = pop_q;
    byte_d      = byte_q;
    rx_next_n_d = 1'b1;
    case (pop_q)
      P_IDLE: begin
        if (rx_ready && !fifo_full) begin
          byte_d      = rx_data;
          rx_next_n_d = 1'b0;
          pop_d       = P_WAIT;
        end
      end
      P_WAIT:  pop_d = P_IDLE;
      default: pop_d = P_IDLE;
    endcase
  end

  // Sequence parser, advanced once per captured byte (in P_WAIT).
  always_comb begin
    parse_d = parse_q;
    is_make = 1'b0;
    is_brk  = 1'b0;
    key_ext = 1'b0;
    if (pop_q == P_WAIT) begin
      if (byte_q == PS2_ERR0 || byte_q == PS2_ERR1) begin
        parse_d = S_IDLE;
      end else begin
        case (parse_q)
          S_IDLE: begin
            if (byte_q == PS2_EXT)      parse_d = S_EXT;
            else if (byte_q == PS2_BRK) parse_d = S_BRK;
            else                        is_make = 1'b1;
          end
          S_EXT: begin
            if (byte_q == PS2_BRK) begin
              parse_d = S_EXT_BRK;
            end else if (byte_q != PS2_EXT) begin
              is_make = 1'b1;
              key_ext = 1'b1;
              parse_d = S_IDLE;
            end
          end
          S_BRK: begin
            parse_d = S_IDLE;
            if (byte_q != PS2_EXT && byte_q != PS2_BRK) is_brk = 1'b1;
          end
          S_EXT_BRK: begin
            parse_d = S_IDLE;
            if (byte_q != PS2_EXT && byte_q != PS2_BRK) begin
              is_brk  = 1'b1;
              key_ext = 1'b1;
            end
          end
          default: parse_d = S_IDLE;
        endcase
      end
    end
  end

  assign key_idx   = held_index(key_ext, byte_q[6:0]);
  assign tracked   = ~byte_q[7];
  assign held_hit  = tracked & held_q[key_idx];
  assign shift_now = held_q[LSHIFT_IDX] | held_q[RSHIFT_IDX];

  // Held bitmap, press counter and event generation.
  always_comb begin
    held_d      = held_q;
    cnt_d       = cnt_q;
    last_make_d = last_make_q;
    push        = 1'b0;
    push_ev     = '0;
    push_ev.shift = shift_now;
    push_ev.ext   = key_ext;
    push_ev.code  = byte_q;
    if (is_make) begin
      if (!held_hit) begin
        if (tracked) held_d[key_idx] = 1'b1;
        push        = 1'b1;
        last_make_d = byte_q;
        if (CNT_SAT != 0 && (&cnt_q)) cnt_d = cnt_q;
        else                          cnt_d = cnt_q + 1'b1;
      end else if (REPEAT_EN != 0) begin
        push        = 1'b1;
        push_ev.rpt = 1'b1;
      end
    end else if (is_brk) begin
      if (tracked) held_d[key_idx] = 1'b0;
      push        = 1'b1;
      push_ev.brk = 1'b1;
    end
    key_down_d = |held_d;
    ovf_d      = ovf_q | rx_overflow;
  end

  // State registers; reset also discards any partial prefix sequence.
  always_ff @(posedge clk) begin
    if (clrn) begin
      pop_q       <= P_IDLE;
      parse_q     <= S_IDLE;
      byte_q      <= '0;
      rx_next_n_q <= 1'b1;
      held_q      <= '0;
      key_down_q  <= 1'b0;
      cnt_q       <= '0;
      last_make_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      pop_q       <= pop_d;
      parse_q     <= parse_d;
      byte_q      <= byte_d;
      rx_next_n_q <= rx_next_n_d;
      held_q      <= held_d;
      key_down_q  <= key_down_d;
      cnt_q       <= cnt_d;
      last_make_q <= last_make_d;
      ovf_q       <= ovf_d;
    end
  end

  assign fifo_pop = ev_valid & ev_ready;

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_EVENT_W)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push    (push),
    .wr_data (push_ev),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (unused_fifo_count)
  );

  assign head_ev     = key_event_t'(fifo_rd);
  assign ev_valid    = ~fifo_empty;
  assign ev_code     = head_ev.code;
  assign ev_ext      = head_ev.ext;
  assign ev_break    = head_ev.brk;
  assign ev_shift    = head_ev.shift;
  assign ev_repeat   = head_ev.rpt;
  assign rx_next_n   = rx_next_n_q;
  assign key_down    = key_down_q;
  assign press_count = cnt_q;
  assign last_make   = last_make_q;
  assign ps2_ovf     = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder. Four instances:
//   0: defaults, 1: REPEAT_EN=1, 2: depth 4 / 2-bit wrap, 3: depth 4 / 2-bit saturate.
// Each instance has its own receiver byte queue and event log.
module tb_ps2_key_event_decoder;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clrn;
  logic [7:0]   rx_data [N];
  logic [N-1:0] rx_ready, rx_overflow, rx_next_n;
  logic [N-1:0] ev_valid, ev_ready, ev_ext, ev_break, ev_shift, ev_repeat;
  logic [N-1:0] key_down, ps2_ovf;
  logic [7:0]   ev_code [N];
  logic [7:0]   press_count [N];
  logic [7:0]   last_make [N];

  logic [7:0]   rx_buf [N][256];
  int           rx_wr [N];
  int           rx_rd [N];
  logic [11:0]  ev_log [N][256];
  int           ev_cnt [N];
  int           nlow [N];
  int           dbl [N];
  logic [N-1:0] low_prev;

  int tests;
  int fails;

  for (genvar i = 0; i < N; i++) begin : g_dut
    localparam int CW = (i < 2) ? 8 : 2;
    logic [CW-1:0] pc;

    assign rx_ready[i] = (rx_rd[i] != rx_wr[i]);
    assign rx_data[i]  = rx_buf[i][rx_rd[i][7:0]];

    ps2_key_event_decoder #(
      .FIFO_DEPTH ((i < 2) ? 8 : 4),
      .COUNT_W    (CW),
      .CNT_SAT    ((i == 3) ? 1 : 0),
      .REPEAT_EN  ((i == 1) ? 1 : 0)
    ) u_dut (
      .clk         (clk),
      .clrn        (clrn),
      .rx_data     (rx_data[i]),
      .rx_ready    (rx_ready[i]),
      .rx_overflow (rx_overflow[i]),
      .rx_next_n   (rx_next_n[i]),
      .ev_valid    (ev_valid[i]),
      .ev_ready    (ev_ready[i]),
      .ev_code     (ev_code[i]),
      .ev_ext      (ev_ext[i]),
      .ev_break    (ev_break[i]),
      .ev_shift    (ev_shift[i]),
      .ev_repeat   (ev_repeat[i]),
      .key_down    (key_down[i]),
      .press_count (pc),
      .last_make   (last_make[i]),
      .ps2_ovf     (ps2_ovf[i])
    );

    assign press_count[i] = 8'(pc);
  end

  // Receiver model and event logger.
  always @(posedge clk) begin
    if (!clrn) begin
      for (int k = 0; k < N; k++) begin
        low_prev[k] <= !rx_next_n[k];
        if (!rx_next_n[k]) begin
          rx_rd[k] <= rx_rd[k] + 1;
          nlow[k]  <= nlow[k] + 1;
          if (low_prev[k]) dbl[k] <= dbl[k] + 1;
        end
        if (ev_valid[k] && ev_ready[k]) begin
          ev_log[k][ev_cnt[k][7:0]] <= {ev_repeat[k], ev_shift[k], ev_break[k], ev_ext[k], ev_code[k]};
          ev_cnt[k] <= ev_cnt[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int k, input logic [7:0] b);
    rx_buf[k][rx_wr[k][7:0]] = b;
    rx_wr[k] = rx_wr[k] + 1;
  endtask

  function automatic bit all_idle();
    for (int k = 0; k < N; k++) begin
      if (ev_ready[k] && (rx_rd[k] != rx_wr[k])) return 1'b0;
      if (ev_ready[k] && ev_valid[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_drain();
    int n;
    n = 0;
    while (n < 400 && !all_idle()) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", all_idle(), 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b, b1, nl;
    logic [11:0] exp3a [4];
    logic [11:0] exp3b [5];
    logic [7:0]  codes [6];

    exp3a = '{12'h012, 12'h41C, 12'h61C, 12'h612};
    exp3b = '{12'h012, 12'h41C, 12'hC1C, 12'h61C, 12'h612};
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
    tests = 0;
    fails = 0;
    clrn = 1'b1;
    ev_ready = '1;
    rx_overflow = '0;
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);

    chk("rst_rx_next_n", rx_next_n[0], 1);
    chk("rst_ev_valid", ev_valid[0], 0);
    chk("rst_key_down", key_down[0], 0);
    chk("rst_press_count", press_count[0], 0);
    chk("rst_last_make", last_make[0], 0);
    chk("rst_ps2_ovf", ps2_ovf[0], 0);

    // make then break of 1C
    b = ev_cnt[0]; nl = nlow[0];
    send(0, 8'h1C);
    wait_drain();
    chk("t1_key_down_make", key_down[0], 1);
    send(0, 8'hF0); send(0, 8'h1C);
    wait_drain();
    chk("t1_key_down_brk", key_down[0], 0);
    chk("t1_n_events", ev_cnt[0] - b, 2);
    chk("t1_ev0", ev_log[0][b], 12'h01C);
    chk("t1_ev1", ev_log[0][b+1], 12'h21C);
    chk("t1_press_count", press_count[0], 1);
    chk("t1_last_make", last_make[0], 8'h1C);
    chk("t1_pops", nlow[0] - nl, 3);
    chk("t1_pulse_width", dbl[0], 0);

    // pipeline latency: capture, then event visible two cycles after rx_ready
    do_reset();
    ev_ready[0] = 1'b0;
    send(0, 8'h29);
    @(negedge clk);
    chk("lat_next_n_low", rx_next_n[0], 0);
    chk("lat_valid_early", ev_valid[0], 0);
    @(negedge clk);
    chk("lat_next_n_high", rx_next_n[0], 1);
    chk("lat_valid", ev_valid[0], 1);
    chk("lat_code", ev_code[0], 8'h29);
    ev_ready[0] = 1'b1;
    wait_drain();

    // extended make / break
    do_reset();
    b = ev_cnt[0];
    send(0, 8'hE0); send(0, 8'h75);
    send(0, 8'hE0); send(0, 8'hF0); send(0, 8'h75);
    wait_drain();
    chk("t2_n_events", ev_cnt[0] - b, 2);
    chk("t2_ev0", ev_log[0][b], 12'h175);
    chk("t2_ev1", ev_log[0][b+1], 12'h375);
    chk("t2_press_count", press_count[0], 1);
    chk("t2_key_down", key_down[0], 0);

    // shift + repeat, with and without repeat reporting
    do_reset();
    b = ev_cnt[0]; b1 = ev_cnt[1];
    for (int k = 0; k < 2; k++) begin
      send(k, 8'h12); send(k, 8'h1C); send(k, 8'h1C);
      send(k, 8'hF0); send(k, 8'h1C); send(k, 8'hF0); send(k, 8'h12);
    end
    wait_drain();
    chk("t3_norep_n", ev_cnt[0] - b, 4);
    for (int j = 0; j < 4; j++) chk($sformatf("t3_norep_ev%0d", j), ev_log[0][b+j], exp3a[j]);
    chk("t3_rep_n", ev_cnt[1] - b1, 5);
    for (int j = 0; j < 5; j++) chk($sformatf("t3_rep_ev%0d", j), ev_log[1][b1+j], exp3b[j]);
    chk("t3_norep_count", press_count[0], 2);
    chk("t3_rep_count", press_count[1], 2);
    chk("t3_last_make", last_make[0], 8'h1C);
    chk("t3_key_down", key_down[0], 0);

    // error byte cancels prefix
    do_reset();
    b = ev_cnt[0];
    send(0, 8'hE0); send(0, 8'h00); send(0, 8'h1C);
    wait_drain();
    chk("t4_err_n", ev_cnt[0] - b, 1);
    chk("t4_err_ev", ev_log[0][b], 12'h01C);

    // dropped prefix in break state
    do_reset();
    b = ev_cnt[0];
    send(0, 8'hF0); send(0, 8'hE0); send(0, 8'h1C);
    wait_drain();
    chk("t4_drop_n", ev_cnt[0] - b, 1);
    chk("t4_drop_ev", ev_log[0][b], 12'h01C);
    chk("t4_drop_count", press_count[0], 1);

    // reset discards a pending E0
    do_reset();
    b = ev_cnt[0];
    send(0, 8'hE0);
    wait_drain();
    do_reset();
    send(0, 8'h1C);
    wait_drain();
    chk("t4_rst_n", ev_cnt[0] - b, 1);
    chk("t4_rst_ev", ev_log[0][b], 12'h01C);

    // untracked codes never count as held; break of an unheld key still emits
    do_reset();
    b = ev_cnt[0];
    send(0, 8'h83); send(0, 8'h83); send(0, 8'hF0); send(0, 8'h2A);
    wait_drain();
    chk("t5_n", ev_cnt[0] - b, 3);
    chk("t5_ev0", ev_log[0][b], 12'h083);
    chk("t5_ev1", ev_log[0][b+1], 12'h083);
    chk("t5_ev2", ev_log[0][b+2], 12'h22A);
    chk("t5_count", press_count[0], 2);
    chk("t5_key_down", key_down[0], 0);

    // backpressure on depth-4 instances
    do_reset();
    ev_ready[2] = 1'b0; ev_ready[3] = 1'b0;
    b = ev_cnt[2]; nl = nlow[2];
    for (int j = 0; j < 6; j++) begin
      send(2, codes[j]); send(3, codes[j]);
    end
    repeat (40) @(negedge clk);
    chk("t6_left2", rx_wr[2] - rx_rd[2], 2);
    chk("t6_left3", rx_wr[3] - rx_rd[3], 2);
    chk("t6_pops", nlow[2] - nl, 4);
    chk("t6_next_n_idle", rx_next_n[2], 1);
    chk("t6_valid", ev_valid[2], 1);
    chk("t6_head", ev_code[2], 8'h15);
    ev_ready[2] = 1'b1; ev_ready[3] = 1'b1;
    wait_drain();
    chk("t6_n", ev_cnt[2] - b, 6);
    for (int j = 0; j < 6; j++) chk($sformatf("t6_ev%0d", j), ev_log[2][b+j], {4'h0, codes[j]});
    chk("t6_wrap_count", press_count[2], 2);
    chk("t6_sat_count", press_count[3], 3);

    // 5 presses on 2-bit counters
    do_reset();
    for (int j = 0; j < 5; j++) begin
      send(2, codes[j]); send(3, codes[j]);
    end
    wait_drain();
    chk("t7_wrap_count", press_count[2], 1);
    chk("t7_sat_count", press_count[3], 3);
    chk("t7_last_make", last_make[3], 8'h2C);

    // sticky overflow
    @(negedge clk);
    rx_overflow[0] = 1'b1;
    @(negedge clk);
    rx_overflow[0] = 1'b0;
    chk("t8_ovf_set", ps2_ovf[0], 1);
    repeat (5) @(negedge clk);
    chk("t8_ovf_sticky", ps2_ovf[0], 1);
    chk("t8_ovf_other", ps2_ovf[1], 0);
    do_reset();
    chk("t8_ovf_cleared", ps2_ovf[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
